stim_seq_ctrl: RTL and testbench

STIM_SEQ_CTRL -- requirements
Module: stim_seq_ctrl

---
 rtl/stim_seq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_stim_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_seq_ctrl.sv
// -----------------------------------------------------------------------------
// stim_seq_ctrl
//
// Drives a programmable stimulus pattern into a sequence detector under test.
// A small step table holds {sel, val, dwell} per step. A run walks the first
// num_steps entries. Each step sets stim[sel] to val (the other stim bits keep
// their value) and then holds for max(dwell,1) cycles. Any det_match seen while
// the run is active (or in its finishing cycle) raises the sticky pass flag.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   request to run the programmed sequence
//   abort      in   terminate the run in progress
//   cfg_we     in   step-table write enable (dropped while busy)
//   cfg_addr   in   step-table index
//   cfg_wdata  in   {sel[1:0], val, dwell[DWELL_W-1:0]}
//   num_steps  in   number of steps to run, sampled when start is accepted
//   det_match  in   match flag from the detector under test
//   stim       out  stimulus drive; bit k drives detector input i(k+1)
//   busy       out  run in progress (APPLY or HOLD)
//   done       out  one-cycle pulse at normal completion
//   step_idx   out  index of the current step
//   pass       out  sticky: det_match seen during the current or last run
//   fsm_state  out  debug view of the FSM state (IDLE=0 APPLY=1 HOLD=2 FINISH=3)
//
// Handshake: start is a level sampled on a rising edge while IDLE; it is
// accepted only when 1 <= num_steps <= MAX_STEPS, otherwise it has no effect.
// abort is sampled on a rising edge and acts only while busy.
// -----------------------------------------------------------------------------
module stim_seq_ctrl #(
    parameter int MAX_STEPS = 14,
    parameter int DWELL_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_addr,
    input  logic [DWELL_W+2:0] cfg_wdata,
    input  logic [3:0]         num_steps,
    input  logic               det_match,
    output logic [3:0]         stim,
    output logic               busy,
    output logic               done,
    output logic [3:0]         step_idx,
    output logic               pass,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_HOLD   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [4:0] MAX_STEPS_W = 5'(MAX_STEPS);

    state_t state_q;
    state_t state_d;

    // Step table deliberately has no reset: a reset must not erase the program.
    logic [DWELL_W+2:0] table_q [MAX_STEPS];

    logic [3:0]         num_q;
    logic [DWELL_W-1:0] dwell_q;

    logic [DWELL_W+2:0] entry;
    logic [1:0]         entry_sel;
    logic               entry_val;
    logic [DWELL_W-1:0] entry_dwell;
    logic [DWELL_W-1:0] dwell_eff;

    logic start_ok;
    logic last_step;
    logic hold_last;
    logic table_wr;

    // ------------------------------------------------------------------
    // Decode of the entry for the current step
    // ------------------------------------------------------------------
    assign entry       = table_q[step_idx];
    assign entry_sel   = entry[DWELL_W+2:DWELL_W+1];
    assign entry_val   = entry[DWELL_W];
    assign entry_dwell = entry[DWELL_W-1:0];
    // A zero dwell behaves as a dwell of one so every step is observable.
    assign dwell_eff   = (entry_dwell == '0) ? DWELL_W'(1) : entry_dwell;

    assign start_ok  = start && (num_steps != 4'd0) && ({1'b0, num_steps} <= MAX_STEPS_W);
    assign last_step = (step_idx == (num_q - 4'd1));
    assign hold_last = (dwell_q == DWELL_W'(1));

    assign table_wr  = cfg_we && !busy && !reset && ({1'b0, cfg_addr} < MAX_STEPS_W);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // start wins over a simultaneous abort: abort only acts while busy.
                if (start_ok) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                busy    = 1'b1;
                state_d = abort ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                busy = 1'b1;
                // abort takes priority over the step advance.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (hold_last) begin
                    state_d = last_step ? S_FINISH : S_APPLY;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fsm_state = state_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stim     <= 4'd0;
            step_idx <= 4'd0;
            pass     <= 1'b0;
            num_q    <= 4'd0;
            dwell_q  <= '0;
        end else begin
            // busy and done are both zero in IDLE, so the clear below on an
            // accepted start never competes with this set.
            if ((busy || done) && det_match) begin
                pass <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        num_q    <= num_steps;
                        step_idx <= 4'd0;
                        stim     <= 4'd0;
                        pass     <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (abort) begin
                        stim <= 4'd0;
                    end else begin
                        stim[entry_sel] <= entry_val;
                        dwell_q         <= dwell_eff;
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        stim <= 4'd0;
                    end else if (!hold_last) begin
                        dwell_q <= dwell_q - DWELL_W'(1);
                    end else if (!last_step) begin
                        step_idx <= step_idx + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Step table
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (table_wr) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

endmodule

// File: tb/tb_stim_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stim_seq_ctrl
//
// Every cycle the driver sets the inputs on the falling edge and asks the
// reference model what the outputs must look like after the next rising edge;
// that expectation goes into exp_q. The monitor pops one entry per rising edge
// and compares it against the DUT outputs.
//
// The reference model works on whole runs: when a start is accepted it expands
// the step table into a per-cycle plan (one APPLY cycle, then max(dwell,1) hold
// cycles per step, then one done cycle) and replays that plan, cutting it short
// on abort or reset.
// -----------------------------------------------------------------------------
module tb_stim_seq_ctrl;

    localparam int MAX_STEPS = 14;
    localparam int DWELL_W   = 12;
    localparam int WD_W      = DWELL_W + 3;

    // Observation record: {busy, done, stim[3:0], step_idx[3:0], pass}
    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] stim;
        logic [3:0] idx;
        logic       pass;
    } obs_t;

    // ---------------- clock / reset block ----------------
    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            abort;
    logic            cfg_we;
    logic [3:0]      cfg_addr;
    logic [WD_W-1:0] cfg_wdata;
    logic [3:0]      num_steps;
    logic            det_match;
    logic [3:0]      stim;
    logic            busy;
    logic            done;
    logic [3:0]      step_idx;
    logic            pass;
    logic [1:0]      fsm_state;

    always #5 clk = ~clk;

    stim_seq_ctrl #(
        .MAX_STEPS (MAX_STEPS),
        .DWELL_W   (DWELL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .num_steps (num_steps),
        .det_match (det_match),
        .stim      (stim),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx),
        .pass      (pass),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [10:0]     exp_q[$];
    int              n_tests = 0;
    int              n_fail  = 0;

    // ---------------- reference model state ----------------
    logic [WD_W-1:0] ref_tab [MAX_STEPS];
    obs_t            plan[$];
    obs_t            cur;

    function automatic logic [WD_W-1:0] mk(input int sel, input int val, input int dwell);
        logic [WD_W-1:0] w;
        w = {2'(sel), 1'(val), DWELL_W'(dwell)};
        return w;
    endfunction

    // Expand the table into the per-cycle outputs of a complete run.
    task automatic build_plan(input int n);
        logic [3:0]      s;
        logic [WD_W-1:0] e;
        int              d;
        obs_t            o;
        s = 4'd0;
        plan.delete();
        for (int k = 0; k < n; k++) begin
            e = ref_tab[k];
            d = int'(e[DWELL_W-1:0]);
            if (d == 0) d = 1;
            o = '{busy: 1'b1, done: 1'b0, stim: s, idx: 4'(k), pass: 1'b0};
            plan.push_back(o);
            s[e[WD_W-1:WD_W-2]] = e[DWELL_W];
            for (int j = 0; j < d; j++) begin
                o = '{busy: 1'b1, done: 1'b0, stim: s, idx: 4'(k), pass: 1'b0};
                plan.push_back(o);
            end
        end
        o = '{busy: 1'b0, done: 1'b1, stim: s, idx: 4'(n - 1), pass: 1'b0};
        plan.push_back(o);
    endtask

    // Predict the outputs after the coming rising edge from the current inputs.
    task automatic model_step();
        obs_t nxt;
        obs_t p;
        if (reset) begin
            plan.delete();
            nxt = '0;
        end else begin
            nxt      = cur;
            nxt.done = 1'b0;
            if ((cur.busy || cur.done) && det_match) nxt.pass = 1'b1;
            if (cfg_we && !cur.busy && int'(cfg_addr) < MAX_STEPS)
                ref_tab[cfg_addr] = cfg_wdata;
            if (cur.busy && abort) begin
                plan.delete();
                nxt.busy = 1'b0;
                nxt.stim = 4'd0;
            end else if (cur.busy || cur.done) begin
                if (plan.size() > 0) begin
                    p        = plan.pop_front();
                    nxt.busy = p.busy;
                    nxt.done = p.done;
                    nxt.stim = p.stim;
                    nxt.idx  = p.idx;
                end else begin
                    nxt.busy = 1'b0;
                end
            end else if (start && num_steps >= 4'd1 && int'(num_steps) <= MAX_STEPS) begin
                build_plan(int'(num_steps));
                p        = plan.pop_front();
                nxt.busy = p.busy;
                nxt.done = p.done;
                nxt.stim = p.stim;
                nxt.idx  = p.idx;
                nxt.pass = 1'b0;
            end
        end
        exp_q.push_back(nxt);
        cur = nxt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic s, input logic a, input logic [3:0] n,
                              input logic d, input logic w, input logic [3:0] ad,
                              input logic [WD_W-1:0] wd, input logic r);
        start     = s;
        abort     = a;
        num_steps = n;
        det_match = d;
        cfg_we    = w;
        cfg_addr  = ad;
        cfg_wdata = wd;
        reset     = r;
        model_step();
    endtask

    task automatic drive(input logic s, input logic a, input logic [3:0] n,
                         input logic d, input logic w, input logic [3:0] ad,
                         input logic [WD_W-1:0] wd, input logic r);
        @(negedge clk);
        set_inputs(s, a, n, d, w, ad, wd, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'd0, 0, 0, 4'd0, '0, 0);
    endtask

    task automatic wr(input int ad, input logic [WD_W-1:0] wd);
        drive(0, 0, 4'd0, 0, 1, 4'(ad), wd, 0);
    endtask

    task automatic go(input int n);
        drive(1, 0, 4'(n), 0, 0, 4'd0, '0, 0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        obs_t e;
        obs_t g;
        #1;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL no_expectation t=%0t: DUT output with empty expected queue", $time);
        end else begin
            e = obs_t'(exp_q.pop_front());
            g = '{busy: busy, done: done, stim: stim, idx: step_idx, pass: pass};
            if (g !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got busy=%b done=%b stim=%b idx=%0d pass=%b, required busy=%b done=%b stim=%b idx=%0d pass=%b",
                         $time, g.busy, g.done, g.stim, g.idx, g.pass,
                         e.busy, e.done, e.stim, e.idx, e.pass);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cur = '0;
        set_inputs(0, 0, 4'd0, 0, 0, 4'd0, '0, 1);
        idle(0);
        drive(0, 0, 4'd0, 0, 0, 4'd0, '0, 1);
        drive(0, 0, 4'd0, 0, 0, 4'd0, '0, 1);

        // Program every entry so no run ever reads an unwritten slot.
        for (int i = 0; i < MAX_STEPS; i++)
            wr(i, mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 4)));
        wr(0, mk(0, 1, 3));
        wr(1, mk(2, 1, 2));
        wr(15, mk(3, 1, 7));          // out-of-range address: dropped

        // Nominal two-step run.
        go(2);
        idle(10);

        // Starts with an illegal step count are ignored.
        go(0);
        idle(3);
        go(15);
        idle(3);

        // Zero dwell behaves as one.
        wr(0, mk(1, 1, 0));
        go(1);
        idle(5);
        wr(0, mk(0, 1, 3));

        // Abort during the hold of step 1, then a clean rerun.
        go(2);
        idle(5);
        drive(0, 1, 4'd0, 0, 0, 4'd0, '0, 0);
        idle(3);
        go(2);
        idle(10);

        // Table write while busy is dropped; rerun keeps the original timing.
        go(2);
        idle(2);
        drive(0, 0, 4'd0, 0, 1, 4'd0, mk(3, 1, 9), 0);
        idle(8);
        go(2);
        idle(10);

        // det_match pulse mid-run sets pass; it holds past done and clears on start.
        go(2);
        idle(3);
        drive(0, 0, 4'd0, 1, 0, 4'd0, '0, 0);
        idle(8);
        go(2);
        idle(10);

        // Reset in HOLD, then the same run with the table intact.
        go(2);
        idle(3);
        drive(0, 0, 4'd0, 0, 0, 4'd0, '0, 1);
        idle(2);
        go(2);
        idle(10);

        // start together with abort in IDLE is accepted; abort and start
        // elsewhere are ignored; det_match in the done cycle counts.
        drive(1, 1, 4'd2, 0, 0, 4'd0, '0, 0);
        idle(6);
        drive(1, 0, 4'd1, 0, 0, 4'd0, '0, 0);
        drive(0, 1, 4'd0, 1, 0, 4'd0, '0, 0);
        idle(3);
        go(1);
        idle(1);
        drive(1, 0, 4'd3, 0, 0, 4'd0, '0, 0);
        idle(3);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(0, 7) == 0,
                  $urandom_range(0, 29) == 0,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 14) == 0,
                  $urandom_range(0, 5) == 0,
                  4'($urandom_range(0, 15)),
                  mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 5)),
                  $urandom_range(0, 199) == 0);
        end
        idle(40);

        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
